// File: rtl/down_counter_timer.sv
// Loadable down-counting timer: decrements once per prescaled tick, pulses done on expiry, optional auto-reload.
// done is registered and appears the cycle after the expiring tick; start-to-done is N*(prescale+1) cycles.
module down_counter_timer #(
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [7:0]       expire_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload_reg;
    logic [PRE_W-1:0] presc;
    logic             tick;
    logic             expire;
    logic             can_start;

    // load and stop both suppress the tick, so a loaded or paused cycle never decrements.
    // >= keeps a live reduction of prescale from stranding the prescaler above the compare value.
    always_comb begin
        tick      = (state == RUN) && !load && !stop && (presc >= prescale);
        expire    = tick && (count == WIDTH'(1));
        can_start = start && !stop && (load ? (load_val != '0) : (count != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, PAUSE: begin
                if (can_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (load) begin
                    if (load_val == '0) begin
                        state_nxt = IDLE;
                    end
                end else if (stop) begin
                    state_nxt = PAUSE;
                end else if (tick && ((count == '0) || ((count == WIDTH'(1)) && !auto_reload))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            reload_reg <= '0;
            presc      <= '0;
            done       <= 1'b0;
            expire_cnt <= '0;
        end else begin
            if (load) begin
                count      <= load_val;
                reload_reg <= load_val;
                presc      <= '0;
            end else if (tick) begin
                presc <= '0;
                if (count > WIDTH'(1)) begin
                    count <= count - WIDTH'(1);
                end else if (count == WIDTH'(1)) begin
                    count <= auto_reload ? reload_reg : '0;
                end
            end else if ((state == RUN) && !stop) begin
                presc <= presc + PRE_W'(1);
            end

            done <= expire;
            if (expire && (expire_cnt != 8'hFF)) begin
                expire_cnt <= expire_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer with hand-computed expectations.
module tb_down_counter_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [31:0] load_val = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        auto_reload = 1'b0;
    logic [7:0]  prescale = '0;
    logic [31:0] count;
    logic        busy;
    logic        done;
    logic [7:0]  expire_cnt;

    int tests = 0;
    int fails = 0;
    int exp_pre[5] = '{4, 3, 3, 2, 2};

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(32), .PRE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .expire_cnt  (expire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #5 rst = 1'b1;
        #1;
        check("rst_count", count, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_expire", 32'(expire_cnt), 32'd0);
        #9 rst = 1'b0;
        #1;
        check("post_rst_count", count, 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_zero_busy", 32'(busy), 32'd0);
        check("start_zero_count", count, 32'd0);
        cyc();
        check("start_zero_busy2", 32'(busy), 32'd0);

        // One-shot, prescale 0
        load_val = 32'd4; prescale = 8'd0; auto_reload = 1'b0;
        load = 1'b1; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        check("os_load_count", count, 32'd4);
        check("os_load_busy", 32'(busy), 32'd1);
        check("os_load_done", 32'(done), 32'd0);
        for (int i = 3; i >= 0; i--) begin
            cyc();
            check($sformatf("os_count_%0d", i), count, 32'(i));
            check($sformatf("os_done_%0d", i), 32'(done), (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("os_busy_%0d", i), 32'(busy), (i != 0) ? 32'd1 : 32'd0);
        end
        check("os_expire", 32'(expire_cnt), 32'd1);
        cyc();
        check("os_done_clear", 32'(done), 32'd0);
        check("os_idle_busy", 32'(busy), 32'd0);
        check("os_idle_count", count, 32'd0);

        // Prescaled periodic: tick every 3 cycles, period 3 ticks
        pulse_rst();
        load_val = 32'd3; prescale = 8'd2; auto_reload = 1'b1;
        load = 1'b1; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        check("per_load_count", count, 32'd3);
        for (int k = 1; k <= 27; k++) begin
            cyc();
            check($sformatf("per_count_%0d", k), count, 32'(3 - ((k / 3) % 3)));
            check($sformatf("per_done_%0d", k), 32'(done), (k % 9 == 0) ? 32'd1 : 32'd0);
            check($sformatf("per_busy_%0d", k), 32'(busy), 32'd1);
        end
        check("per_expire", 32'(expire_cnt), 32'd3);

        // Pause / resume
        pulse_rst();
        load_val = 32'd10; prescale = 8'd0; auto_reload = 1'b0;
        load = 1'b1; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        check("pr_load_count", count, 32'd10);
        for (int i = 9; i >= 6; i--) begin
            cyc();
            check($sformatf("pr_run_%0d", i), count, 32'(i));
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("pr_stop_count", count, 32'd6);
        check("pr_stop_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("pr_hold_count_%0d", i), count, 32'd6);
            check($sformatf("pr_hold_busy_%0d", i), 32'(busy), 32'd0);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("pr_resume_count", count, 32'd6);
        check("pr_resume_busy", 32'(busy), 32'd1);
        for (int i = 5; i >= 0; i--) begin
            cyc();
            check($sformatf("pr_after_%0d", i), count, 32'(i));
            check($sformatf("pr_done_%0d", i), 32'(done), (i == 0) ? 32'd1 : 32'd0);
        end
        check("pr_expire", 32'(expire_cnt), 32'd1);

        // stop+start together in RUN pauses
        pulse_rst();
        load_val = 32'd5;
        load = 1'b1; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        check("ss_load", count, 32'd5);
        cyc();
        check("ss_run", count, 32'd4);
        stop = 1'b1; start = 1'b1;
        cyc();
        stop = 1'b0; start = 1'b0;
        check("ss_busy", 32'(busy), 32'd0);
        check("ss_count", count, 32'd4);
        cyc();
        check("ss_frozen", count, 32'd4);

        // Reload while running clears the prescaler
        pulse_rst();
        load_val = 32'd4; prescale = 8'd1;
        load = 1'b1; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        check("rl_load", count, 32'd4);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("rl_pre_%0d", i), count, 32'(exp_pre[i]));
        end
        load_val = 32'd7; load = 1'b1;
        cyc();
        load = 1'b0;
        check("rl_new_count", count, 32'd7);
        check("rl_new_busy", 32'(busy), 32'd1);
        cyc();
        check("rl_presc_hold", count, 32'd7);
        cyc();
        check("rl_presc_tick", count, 32'd6);

        // load 0 while running forces IDLE with no done
        load_val = 32'd0; load = 1'b1;
        cyc();
        load = 1'b0;
        check("lz_count", count, 32'd0);
        check("lz_busy", 32'(busy), 32'd0);
        check("lz_done", 32'(done), 32'd0);
        cyc();
        check("lz_done2", 32'(done), 32'd0);
        check("lz_expire", 32'(expire_cnt), 32'd0);

        // Reset mid-run
        pulse_rst();
        load_val = 32'd8; prescale = 8'd0; auto_reload = 1'b0;
        load = 1'b1; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        for (int i = 7; i >= 5; i--) begin
            cyc();
            check($sformatf("mr_run_%0d", i), count, 32'(i));
        end
        rst = 1'b1;
        #1;
        check("mr_async_count", count, 32'd0);
        check("mr_async_busy", 32'(busy), 32'd0);
        check("mr_async_done", 32'(done), 32'd0);
        cyc();
        check("mr_hold_done", 32'(done), 32'd0);
        check("mr_hold_count", count, 32'd0);
        rst = 1'b0;
        cyc();
        check("mr_idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("mr_start_busy", 32'(busy), 32'd0);
        check("mr_start_count", count, 32'd0);

        // Auto-reload of 1: done every cycle, expire_cnt saturates
        load_val = 32'd1; auto_reload = 1'b1;
        load = 1'b1; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        check("sat_load_count", count, 32'd1);
        check("sat_load_busy", 32'(busy), 32'd1);
        check("sat_load_done", 32'(done), 32'd0);
        for (int k = 1; k <= 300; k++) begin
            cyc();
            check($sformatf("sat_done_%0d", k), 32'(done), 32'd1);
            check($sformatf("sat_count_%0d", k), count, 32'd1);
            check($sformatf("sat_expire_%0d", k), 32'(expire_cnt), (k > 255) ? 32'd255 : 32'(k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
